// File: rtl/lcd_zoom_pkg.sv
// Shared types for the LCD zoom controller: command codes, FSM states, view modes.
package lcd_zoom_pkg;

  typedef enum logic [2:0] {
    CmdLoad    = 3'd0,
    CmdZoomIn  = 3'd1,
    CmdZoomFit = 3'd2,
    CmdShR     = 3'd3,
    CmdShL     = 3'd4,
    CmdShU     = 3'd5,
    CmdShD     = 3'd6,
    CmdRsvd    = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSetup,
    StOut
  } state_e;

  typedef enum logic {
    ModeFit,
    ModeZoom
  } mode_e;

  // Origin that centres a win-wide window in an img-wide axis.
  function automatic int unsigned centre(int unsigned img, int unsigned win);
    return (img - win + 1) / 2;
  endfunction

endpackage

// File: rtl/lcd_frame_ram.sv
// Frame store: one synchronous write port, one synchronous read port, no reset.
module lcd_frame_ram #(
  parameter int unsigned Depth = 108,
  parameter int unsigned Width = 8,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [Aw-1:0]    waddr,
  input  logic [Width-1:0] wdata,
  input  logic [Aw-1:0]    raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/lcd_zoom_ctrl.sv
// LCD frame loader and WIN x WIN fit/zoom view streamer with clamped panning.
// Optional cmd_err port enabled by defining LCD_ZOOM_ERR_EN.
module lcd_zoom_ctrl
  import lcd_zoom_pkg::*;
#(
  parameter int unsigned IMG_W = 12,
  parameter int unsigned IMG_H = 9,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned WIN   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PIX_W-1:0] datain,
  input  logic [2:0]       cmd,
  input  logic             cmd_valid,
  output logic [PIX_W-1:0] dataout,
  output logic             output_valid,
  output logic             busy
`ifdef LCD_ZOOM_ERR_EN
  ,
  output logic             cmd_err
`endif
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned AW   = $clog2(NPIX);
  localparam int unsigned VW   = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned NV   = WIN * WIN;
  localparam int unsigned CW   = $clog2(NV + 1);
  localparam int unsigned RS   = IMG_H / WIN;
  localparam int unsigned CS   = IMG_W / WIN;
  localparam int unsigned R0   = centre(IMG_H, WIN);
  localparam int unsigned C0   = centre(IMG_W, WIN);
  localparam int unsigned RMAX = IMG_H - WIN;
  localparam int unsigned CMAX = IMG_W - WIN;

  state_e           state_q;
  mode_e            mode_q;
  logic [AW-1:0]    orow_q, ocol_q;
  logic [AW-1:0]    ld_cnt_q;
  logic [VW-1:0]    vi_q, vj_q;
  logic [CW-1:0]    cnt_q;
  logic             rvalid_q, output_valid_q;
  logic [PIX_W-1:0] dataout_q;
  logic [PIX_W-1:0] rdata;

  cmd_e          cmd_in;
  logic          accept, rd_en;
  logic [AW-1:0] sh_row, sh_col;
  logic [AW-1:0] rd_row, rd_col, raddr;

  assign cmd_in = cmd_e'(cmd);
  assign accept = (state_q == StIdle) && cmd_valid;
  // SETUP issues view pixel 0; OUT issues the remaining NV-1 reads.
  assign rd_en  = (state_q == StSetup) || ((state_q == StOut) && (cnt_q < CW'(NV - 1)));

  // Candidate panned origin; equals the current origin when the shift is clamped.
  always_comb begin
    sh_row = orow_q;
    sh_col = ocol_q;
    case (cmd_in)
      CmdShR:  if (ocol_q < AW'(CMAX)) sh_col = ocol_q + AW'(1);
      CmdShL:  if (ocol_q != '0)       sh_col = ocol_q - AW'(1);
      CmdShU:  if (orow_q != '0)       sh_row = orow_q - AW'(1);
      CmdShD:  if (orow_q < AW'(RMAX)) sh_row = orow_q + AW'(1);
      default: ;
    endcase
  end

  always_comb begin
    if (mode_q == ModeFit) begin
      rd_row = AW'(RS / 2) + AW'(vi_q) * AW'(RS);
      rd_col = AW'(CS / 2) + AW'(vj_q) * AW'(CS);
    end else begin
      rd_row = orow_q + AW'(vi_q);
      rd_col = ocol_q + AW'(vj_q);
    end
    raddr = rd_row * AW'(IMG_W) + rd_col;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      mode_q         <= ModeFit;
      orow_q         <= AW'(R0);
      ocol_q         <= AW'(C0);
      ld_cnt_q       <= '0;
      vi_q           <= '0;
      vj_q           <= '0;
      cnt_q          <= '0;
      rvalid_q       <= 1'b0;
      output_valid_q <= 1'b0;
      dataout_q      <= '0;
    end else begin
      rvalid_q       <= rd_en;
      output_valid_q <= rvalid_q;
      if (rvalid_q) dataout_q <= rdata;
      if (rd_en) begin
        if (vj_q == VW'(WIN - 1)) begin
          vj_q <= '0;
          vi_q <= vi_q + VW'(1);
        end else begin
          vj_q <= vj_q + VW'(1);
        end
      end
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            vi_q     <= '0;
            vj_q     <= '0;
            cnt_q    <= '0;
            ld_cnt_q <= '0;
            state_q  <= StSetup;
            case (cmd_in)
              CmdLoad: state_q <= StLoad;
              CmdZoomIn: begin
                if (mode_q == ModeFit) begin
                  mode_q <= ModeZoom;
                  orow_q <= AW'(R0);
                  ocol_q <= AW'(C0);
                end
              end
              CmdZoomFit: mode_q <= ModeFit;
              CmdShR, CmdShL, CmdShU, CmdShD: begin
                if (mode_q == ModeZoom) begin
                  orow_q <= sh_row;
                  ocol_q <= sh_col;
                end
              end
              default: ;
            endcase
          end
        end
        StLoad: begin
          ld_cnt_q <= ld_cnt_q + AW'(1);
          if (ld_cnt_q == AW'(NPIX - 1)) begin
            mode_q  <= ModeFit;
            orow_q  <= AW'(R0);
            ocol_q  <= AW'(C0);
            state_q <= StSetup;
          end
        end
        StSetup: state_q <= StOut;
        StOut: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(NV - 1)) state_q <= StIdle;
        end
      endcase
    end
  end

  lcd_frame_ram #(
    .Depth(NPIX),
    .Width(PIX_W),
    .Aw   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (state_q == StLoad),
    .waddr(ld_cnt_q),
    .wdata(datain),
    .raddr(raddr),
    .rdata(rdata)
  );

  // Busy stays up until the last pipelined pixel has left the output register.
  assign busy         = (state_q != StIdle) || output_valid_q;
  assign output_valid = output_valid_q;
  assign dataout      = dataout_q;

`ifdef LCD_ZOOM_ERR_EN
  logic err_q;
  logic is_shift, err_cond;

  assign is_shift = (cmd_in == CmdShR) || (cmd_in == CmdShL) ||
                    (cmd_in == CmdShU) || (cmd_in == CmdShD);
  assign err_cond = (cmd_in == CmdRsvd) ||
                    (is_shift && ((mode_q == ModeFit) ||
                                  ((sh_row == orow_q) && (sh_col == ocol_q))));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= accept && err_cond;
  end

  assign cmd_err = err_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
